// File: rtl/systolic_feed_ctrl.sv
// Diagonal skew feeder: row i shows a beat i+1 edges after acceptance; start/done pulses bracket each tile.
// Backpressure: in_ready drops for the N drain cycles after a last beat; bubbles feed zero/invalid slots.
module systolic_feed_ctrl #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    input  logic            in_last,
    output logic            start_out,
    output logic [N*DW-1:0] row_data,
    output logic [N-1:0]    row_valid,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   tile_beats
);

    localparam int DCW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t         state;
    logic [DCW-1:0] drain_cnt;
    logic [CW-1:0]  beat_cnt;
    logic           fire;
    logic [CW-1:0]  beat_nxt;

    assign in_ready = (state != DRAIN);
    assign fire     = in_valid & in_ready;

    // First beat of a tile restarts the count at 1; later beats saturate.
    always_comb begin
        beat_nxt = beat_cnt;
        if (state == IDLE)
            beat_nxt = {{(CW-1){1'b0}}, 1'b1};
        else if (beat_cnt != {CW{1'b1}})
            beat_nxt = beat_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            beat_cnt   <= '0;
            start_out  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tile_beats <= '0;
        end else begin
            start_out <= fire && (state == IDLE);
            done      <= 1'b0;
            if (fire)
                beat_cnt <= beat_nxt;
            case (state)
                IDLE, STREAM: begin
                    if (fire) begin
                        busy <= 1'b1;
                        if (in_last) begin
                            state      <= DRAIN;
                            drain_cnt  <= DCW'(N-1);
                            tile_beats <= beat_nxt;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    // done lines up with the last beat reaching row N-1; leave one edge later.
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                        if (drain_cnt == DCW'(1))
                            done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Element i is captured with row 0 and then delayed i more edges; invalid slots carry zero.
    for (genvar i = 0; i < N; i++) begin : g_row
        logic [DW-1:0] dly_dat [0:i];
        logic          dly_vld [0:i];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int k = 0; k <= i; k++) begin
                    dly_dat[k] <= '0;
                    dly_vld[k] <= 1'b0;
                end
            end else begin
                dly_vld[0] <= fire;
                dly_dat[0] <= fire ? in_data[i*DW +: DW] : '0;
                for (int k = 1; k <= i; k++) begin
                    dly_vld[k] <= dly_vld[k-1];
                    dly_dat[k] <= dly_dat[k-1];
                end
            end
        end

        assign row_data[i*DW +: DW] = dly_dat[i];
        assign row_valid[i]         = dly_vld[i];
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl with N=3, DW=8: per-cycle hand-computed output tables.
module tb_systolic_feed_ctrl;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int CW = 8;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_data;
    logic            in_last;
    logic            start_out;
    logic [N*DW-1:0] row_data;
    logic [N-1:0]    row_valid;
    logic            busy;
    logic            done;
    logic [CW-1:0]   tile_beats;

    int n_checks = 0;
    int n_errors = 0;

    systolic_feed_ctrl #(.N(N), .DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .start_out  (start_out),
        .row_data   (row_data),
        .row_valid  (row_valid),
        .busy       (busy),
        .done       (done),
        .tile_beats (tile_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, clock once, then compare outputs on the falling edge.
    task automatic cyc(input string tag,
                       input logic v, input logic l, input logic [23:0] d,
                       input logic [23:0] erd, input logic [2:0] erv,
                       input logic est, input logic edn, input logic ebz, input logic erdy);
        in_valid = v;
        in_last  = l;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".row_data"},  32'(row_data),  32'(erd));
        check({tag, ".row_valid"}, 32'(row_valid), 32'(erv));
        check({tag, ".start_out"}, 32'(start_out), 32'(est));
        check({tag, ".done"},      32'(done),      32'(edn));
        check({tag, ".busy"},      32'(busy),      32'(ebz));
        check({tag, ".in_ready"},  32'(in_ready),  32'(erdy));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 24'h030201;
        @(negedge clk);

        // Reset held with in_valid high: nothing may be accepted.
        cyc("rst0", 1, 0, 24'h030201, 24'h0, 3'b000, 0, 0, 0, 1);
        cyc("rst1", 1, 0, 24'h030201, 24'h0, 3'b000, 0, 0, 0, 1);
        cyc("rst2", 1, 0, 24'h030201, 24'h0, 3'b000, 0, 0, 0, 1);
        check("rst.tile_beats", 32'(tile_beats), 32'd0);
        rst_n = 1'b1;
        cyc("idle", 0, 0, 24'h0, 24'h0, 3'b000, 0, 0, 0, 1);

        // Three-beat tile on consecutive cycles.
        cyc("t3.b0", 1, 0, 24'h030201, 24'h000001, 3'b001, 1, 0, 1, 1);
        cyc("t3.b1", 1, 0, 24'h060504, 24'h000204, 3'b011, 0, 0, 1, 1);
        cyc("t3.b2", 1, 1, 24'h090807, 24'h030507, 3'b111, 0, 0, 1, 0);
        check("t3.tile_beats", 32'(tile_beats), 32'd3);
        cyc("t3.d0", 0, 0, 24'h0, 24'h060800, 3'b110, 0, 0, 1, 0);
        cyc("t3.d1", 0, 0, 24'h0, 24'h090000, 3'b100, 0, 1, 1, 0);
        cyc("t3.d2", 0, 0, 24'h0, 24'h000000, 3'b000, 0, 0, 0, 1);

        // Same tile with one bubble after beat 1.
        cyc("bub.b0", 1, 0, 24'h030201, 24'h000001, 3'b001, 1, 0, 1, 1);
        cyc("bub.gap", 0, 0, 24'h0,     24'h000200, 3'b010, 0, 0, 1, 1);
        cyc("bub.b1", 1, 0, 24'h060504, 24'h030004, 3'b101, 0, 0, 1, 1);
        cyc("bub.b2", 1, 1, 24'h090807, 24'h000507, 3'b011, 0, 0, 1, 0);
        cyc("bub.d0", 0, 0, 24'h0,      24'h060800, 3'b110, 0, 0, 1, 0);
        cyc("bub.d1", 0, 0, 24'h0,      24'h090000, 3'b100, 0, 1, 1, 0);
        cyc("bub.d2", 0, 0, 24'h0,      24'h000000, 3'b000, 0, 0, 0, 1);
        check("bub.tile_beats", 32'(tile_beats), 32'd3);

        // Single-beat tile: start and last together.
        cyc("one.b0", 1, 1, 24'h070605, 24'h000005, 3'b001, 1, 0, 1, 0);
        cyc("one.d0", 0, 0, 24'h0,      24'h000600, 3'b010, 0, 0, 1, 0);
        cyc("one.d1", 0, 0, 24'h0,      24'h070000, 3'b100, 0, 1, 1, 0);
        cyc("one.d2", 0, 0, 24'h0,      24'h000000, 3'b000, 0, 0, 0, 1);
        check("one.tile_beats", 32'(tile_beats), 32'd1);

        // Two-beat tile A, then tile B held valid through A's drain.
        cyc("b2b.a0", 1, 0, 24'h030201, 24'h000001, 3'b001, 1, 0, 1, 1);
        cyc("b2b.a1", 1, 1, 24'h060504, 24'h000204, 3'b011, 0, 0, 1, 0);
        check("b2b.a.tile_beats", 32'(tile_beats), 32'd2);
        cyc("b2b.w0", 1, 1, 24'h090807, 24'h030500, 3'b110, 0, 0, 1, 0);
        cyc("b2b.w1", 1, 1, 24'h090807, 24'h060000, 3'b100, 0, 1, 1, 0);
        cyc("b2b.w2", 1, 1, 24'h090807, 24'h000000, 3'b000, 0, 0, 0, 1);
        cyc("b2b.b0", 1, 1, 24'h090807, 24'h000007, 3'b001, 1, 0, 1, 0);
        cyc("b2b.d0", 0, 0, 24'h0,      24'h000800, 3'b010, 0, 0, 1, 0);
        cyc("b2b.d1", 0, 0, 24'h0,      24'h090000, 3'b100, 0, 1, 1, 0);
        cyc("b2b.d2", 0, 0, 24'h0,      24'h000000, 3'b000, 0, 0, 0, 1);
        check("b2b.b.tile_beats", 32'(tile_beats), 32'd1);

        // Reset after two beats of a four-beat tile.
        cyc("mid.b0", 1, 0, 24'h030201, 24'h000001, 3'b001, 1, 0, 1, 1);
        cyc("mid.b1", 1, 0, 24'h060504, 24'h000204, 3'b011, 0, 0, 1, 1);
        rst_n = 1'b0;
        cyc("mid.rst", 1, 0, 24'h090807, 24'h000000, 3'b000, 0, 0, 0, 1);
        check("mid.tile_beats", 32'(tile_beats), 32'd0);
        rst_n = 1'b1;
        cyc("mid.q0", 0, 0, 24'h0, 24'h0, 3'b000, 0, 0, 0, 1);
        cyc("mid.q1", 0, 0, 24'h0, 24'h0, 3'b000, 0, 0, 0, 1);
        cyc("mid.q2", 0, 0, 24'h0, 24'h0, 3'b000, 0, 0, 0, 1);
        cyc("mid.n0", 1, 1, 24'h0c0b0a, 24'h00000a, 3'b001, 1, 0, 1, 0);
        cyc("mid.n1", 0, 0, 24'h0,      24'h000b00, 3'b010, 0, 0, 1, 0);
        cyc("mid.n2", 0, 0, 24'h0,      24'h0c0000, 3'b100, 0, 1, 1, 0);
        cyc("mid.n3", 0, 0, 24'h0,      24'h000000, 3'b000, 0, 0, 0, 1);
        check("mid.n.tile_beats", 32'(tile_beats), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
